// File: rtl/sipo_pkg.sv
// Shared state encoding, defaults and parity helpers for the SIPO receiver.
// Optional parity frame is enabled by defining SIPO_PARITY_CHECK_EN.
package sipo_pkg;

    typedef enum logic {
        SIPO_IDLE = 1'b0,
        SIPO_RECV = 1'b1
    } sipo_state_e;

    localparam int SIPO_DEFAULT_WIDTH = 4;
    localparam bit SIPO_PARITY_EVEN   = 1'b1;

`ifdef SIPO_PARITY_CHECK_EN
    localparam bit SIPO_PARITY_EN = 1'b1;
`else
    localparam bit SIPO_PARITY_EN = 1'b0;
`endif

    // The counter must also reach WIDTH when a parity strobe follows the data bits.
    function automatic int sipo_cnt_w(input int width);
        return $clog2(width + (SIPO_PARITY_EN ? 2 : 1));
    endfunction

    function automatic logic sipo_parity_err(input logic data_xor, input logic par_bit);
        return (data_xor ^ par_bit) ^ ~SIPO_PARITY_EVEN;
    endfunction

endpackage

// File: rtl/sipo_receiver_if.sv
// Serial-side strobes and parallel-side handshake of the SIPO receiver.
// BitCount widens by one state when SIPO_PARITY_CHECK_EN is defined.
interface sipo_receiver_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
);
    localparam int CNT_W = sipo_cnt_w(WIDTH);

    logic             Rx;
    logic             SerialIn;
    logic             Clear;
    logic             Ack;
    logic [WIDTH-1:0] ParallelOut;
    logic             Valid;
    logic             Busy;
    logic [CNT_W-1:0] BitCount;
    logic             Overrun;
    logic             ParityErr;

    modport master (
        output Rx, SerialIn, Clear, Ack,
        input  ParallelOut, Valid, Busy, BitCount, Overrun, ParityErr
    );

    modport slave (
        input  Rx, SerialIn, Clear, Ack,
        output ParallelOut, Valid, Busy, BitCount, Overrun, ParityErr
    );
endinterface

// File: rtl/sipo_shift_reg.sv
// Data shift register of the SIPO receiver; MSB_FIRST selects the shift direction.
// Behaviour of the word output depends on SIPO_PARITY_CHECK_EN.
module sipo_shift_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] word
);
    logic [WIDTH-1:0] word_q, word_d, word_next;

    always_comb begin
        if (MSB_FIRST) word_next = {word_q[WIDTH-2:0], serial_in};
        else           word_next = {serial_in, word_q[WIDTH-1:1]};
    end

    always_comb begin
        word_d = word_q;
        if (Clear)         word_d = '0;
        else if (shift_en) word_d = word_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) word_q <= '0;
        else       word_q <= word_d;
    end

    // Without parity the completing strobe carries the last data bit, so the
    // finished word must include it; with parity all data bits are already stored.
    assign word = SIPO_PARITY_EN ? word_q : word_next;

endmodule

// File: rtl/sipo_receiver.sv
// Serial-to-parallel receiver: bit counter, IDLE/RECV FSM, holding register and
// Valid/Ack handshake. Define SIPO_PARITY_CHECK_EN for a trailing even-parity strobe.
//
// state     | meaning
// SIPO_IDLE | no bits of the current word captured (BitCount = 0)
// SIPO_RECV | partial word in progress (BitCount >= 1)
module sipo_receiver
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic            Clk,
    input logic            Reset,
    sipo_receiver_if.slave bus
);
    localparam int               CNT_W    = sipo_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIPO_PARITY_EN ? WIDTH : WIDTH - 1);

    sipo_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             shift_en;
    logic             complete;
    logic [WIDTH-1:0] word;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .Clk       (Clk),
        .Reset     (Reset),
        .Clear     (bus.Clear),
        .shift_en  (shift_en),
        .serial_in (bus.SerialIn),
        .word      (word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pout_d   = pout_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        shift_en = 1'b0;
        complete = 1'b0;

        if (valid_q && bus.Ack) valid_d = 1'b0;

        if (bus.Clear) begin
            state_d = SIPO_IDLE;
            cnt_d   = '0;
            ovr_d   = 1'b0;
        end else if (bus.Rx) begin
            unique case (state_q)
                SIPO_IDLE: begin
                    shift_en = 1'b1;
                    cnt_d    = CNT_W'(1);
                    state_d  = SIPO_RECV;
                end
                SIPO_RECV: begin
                    if (cnt_q == LAST_CNT) begin
                        complete = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end

        // An Ack on the completion edge retires the old word, so only an
        // unacknowledged word being overwritten counts as overrun.
        if (complete) begin
            pout_d  = word;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = SIPO_IDLE;
            if (valid_q && !bus.Ack) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= SIPO_IDLE;
            cnt_q   <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (complete) perr_d = sipo_parity_err(^word, bus.SerialIn);
    end

    always_ff @(posedge Clk) begin
        if (Reset) perr_q <= 1'b0;
        else       perr_q <= perr_d;
    end

    assign bus.ParityErr = perr_q;
`else
    assign bus.ParityErr = 1'b0;
`endif

    assign bus.ParallelOut = pout_q;
    assign bus.Valid       = valid_q;
    assign bus.Busy        = (cnt_q != '0);
    assign bus.BitCount    = cnt_q;
    assign bus.Overrun     = ovr_q;

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench for sipo_receiver: an MSB-first and an LSB-first instance share stimulus.
// Parity frames are exercised when SIPO_PARITY_CHECK_EN is defined.
module tb_sipo_receiver;
    import sipo_pkg::*;

    localparam int W     = 4;
    localparam int FRAME = W + (SIPO_PARITY_EN ? 1 : 0);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b0;
    logic sin = 1'b0;
    logic clr = 1'b0;
    logic ack = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sipo_receiver_if #(.WIDTH(W)) if_m ();
    sipo_receiver_if #(.WIDTH(W)) if_l ();

    assign if_m.Rx = rx;  assign if_m.SerialIn = sin;
    assign if_m.Clear = clr;  assign if_m.Ack = ack;
    assign if_l.Rx = rx;  assign if_l.SerialIn = sin;
    assign if_l.Clear = clr;  assign if_l.Ack = ack;

    sipo_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.Clk(clk), .Reset(rst), .bus(if_m));
    sipo_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.Clk(clk), .Reset(rst), .bus(if_l));

    typedef struct {
        logic [3:0] w;
        int         gap;
        bit         ack_first;
        bit         ack_last;
        bit         exp_valid;
        bit         exp_ovr;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input logic b, input logic a);
        rx  = 1'b1;
        sin = b;
        ack = a;
        tick();
        rx  = 1'b0;
        sin = 1'b0;
        ack = 1'b0;
    endtask

    // Bits go out first-to-last as w[3]..w[0]; a trailing parity strobe is added in parity builds.
    task automatic send_word(input logic [3:0] w, input int gap_max, input bit ack_first,
                             input bit ack_last, input bit bad_par);
        logic b;
        for (int i = 0; i < FRAME; i++) begin
            if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
            if (i < W) b = w[W-1-i];
            else       b = (^w) ^ bad_par;
            strobe(b, (i == 0 && ack_first) || (i == FRAME - 1 && ack_last));
        end
    endtask

    task automatic check_word(input string tag, input logic [3:0] w, input bit ev,
                              input bit eo, input bit ep);
        check({tag, " pout_msb"}, 32'(if_m.ParallelOut), 32'(w));
        check({tag, " pout_lsb"}, 32'(if_l.ParallelOut), 32'(rev4(w)));
        check({tag, " valid_msb"}, 32'(if_m.Valid), 32'(ev));
        check({tag, " valid_lsb"}, 32'(if_l.Valid), 32'(ev));
        check({tag, " overrun"}, 32'(if_m.Overrun), 32'(eo));
        check({tag, " busy"}, 32'(if_m.Busy), 32'd0);
        check({tag, " bitcount"}, 32'(if_m.BitCount), 32'd0);
        check({tag, " parityerr"}, 32'(if_m.ParityErr), 32'(ep));
    endtask

    initial begin
        tbl[0]  = '{4'hF, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{4'h0, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{4'hA, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{4'hB, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{4'hC, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{4'h5, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{4'h7, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{4'h7, 5, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{4'h7, 5, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{4'h3, 2, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{4'hA, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{4'hB, 0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        idle(2);
        check("rst pout_msb", 32'(if_m.ParallelOut), 32'd0);
        check("rst pout_lsb", 32'(if_l.ParallelOut), 32'd0);
        check("rst valid", 32'(if_m.Valid), 32'd0);
        check("rst busy", 32'(if_m.Busy), 32'd0);
        check("rst bitcount", 32'(if_m.BitCount), 32'd0);
        check("rst overrun", 32'(if_m.Overrun), 32'd0);
        check("rst parityerr", 32'(if_m.ParityErr), 32'd0);
        rst = 1'b0;

        // All-ones word with the BitCount ramp; parity strobe (if any) is 0 for even parity.
        for (int k = 1; k <= FRAME; k++) begin
            strobe((k <= W) ? 1'b1 : 1'b0, 1'b0);
            if (k < FRAME) begin
                check("ramp bitcount", 32'(if_m.BitCount), 32'(k));
                check("ramp busy", 32'(if_m.Busy), 32'd1);
                check("ramp valid", 32'(if_m.Valid), 32'd0);
            end
        end
        check_word("ones", 4'hF, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            send_word(tbl[i].w, tbl[i].gap, tbl[i].ack_first, tbl[i].ack_last, 1'b0);
            check_word($sformatf("tbl%0d", i), tbl[i].w, tbl[i].exp_valid, tbl[i].exp_ovr, 1'b0);
        end

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr overrun", 32'(if_m.Overrun), 32'd0);
        check("clr pout", 32'(if_m.ParallelOut), 32'hB);
        check("clr valid", 32'(if_m.Valid), 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack valid", 32'(if_m.Valid), 32'd0);
        check("ack pout hold", 32'(if_m.ParallelOut), 32'hB);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("idle ack valid", 32'(if_m.Valid), 32'd0);

        // Partial 4'hC, then Clear with a coincident strobe that must be dropped.
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        check("part bitcount", 32'(if_m.BitCount), 32'd2);
        check("part busy", 32'(if_m.Busy), 32'd1);
        clr = 1'b1; rx = 1'b1; sin = 1'b1;
        tick();
        clr = 1'b0; rx = 1'b0; sin = 1'b0;
        check("abort bitcount", 32'(if_m.BitCount), 32'd0);
        check("abort busy", 32'(if_m.Busy), 32'd0);
        check("abort valid", 32'(if_m.Valid), 32'd0);
        send_word(4'h5, 0, 1'b0, 1'b0, 1'b0);
        check_word("after clear", 4'h5, 1'b1, 1'b0, 1'b0);

        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst bitcount", 32'(if_m.BitCount), 32'd0);
        check("midrst valid", 32'(if_m.Valid), 32'd0);
        check("midrst pout", 32'(if_m.ParallelOut), 32'd0);
        send_word(4'h5, 1, 1'b0, 1'b0, 1'b0);
        check_word("after reset", 4'h5, 1'b1, 1'b0, 1'b0);

`ifdef SIPO_PARITY_CHECK_EN
        send_word(4'hB, 0, 1'b1, 1'b0, 1'b0);
        check_word("parity good", 4'hB, 1'b1, 1'b0, 1'b0);
        send_word(4'hB, 0, 1'b1, 1'b0, 1'b1);
        check_word("parity bad", 4'hB, 1'b1, 1'b0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
